// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM states and flag helpers for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_OR    = 3'b010;
  localparam logic [2:0] OP_NAND  = 3'b011;
  localparam logic [2:0] OP_SHIFT = 3'b100;
  localparam logic [2:0] OP_MUL   = 3'b101;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  // Two's-complement overflow from operand and result sign bits.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// Request/result bundle between the datapath controller and the sequential ALU.
interface seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [2:0]       ALUOp;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [WIDTH-1:0] out;
  logic             N;
  logic             Z;
  logic             C;
  logic             V;
  logic             busy;
  logic             done;

  modport master (
    output start, ALUOp, in1, in2,
    input  out, N, Z, C, V, busy, done
  );

  modport slave (
    input  start, ALUOp, in1, in2,
    output out, N, Z, C, V, busy, done
  );
endinterface

// File: rtl/seq_alu_mul.sv
// Shift-add multiplier datapath: one multiplier bit per cycle after load.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product,
  output logic               last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [CW-1:0]      count_r;
  logic               active_r;
  logic [WIDTH:0]     sum_s;
  logic [2*WIDTH-1:0] acc_next_s;

  // One iteration: conditional add into the high half, then shift right keeping the carry.
  always_comb begin
    sum_s      = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
               + (mplier_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    acc_next_s = {sum_s, acc_r[WIDTH-1:1]};
  end

  // product is the accumulator after the current iteration, so the caller
  // can capture the final value on the same edge that completes it.
  assign product = acc_next_s;
  assign last    = active_r && (count_r == CW'(WIDTH - 1));

  // Operand load and iteration state.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
      active_r <= 1'b0;
    end else if (load) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {(2*WIDTH){1'b0}};
      count_r  <= {CW{1'b0}};
      active_r <= 1'b1;
    end else if (active_r) begin
      acc_r    <= acc_next_s;
      mplier_r <= mplier_r >> 1;
      count_r  <= count_r + CW'(1);
      active_r <= ~last;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle logic/arith/shift ops plus a WIDTH-cycle multiply.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic       clock,
  input  logic       reset,
  seq_alu_if.slave   bus
);

  state_t             state_r;
  state_t             state_next_s;
  logic [WIDTH-1:0]   out_r;
  logic               n_r, z_r, c_r, v_r, busy_r, done_r;

  logic [WIDTH:0]     add_s, sub_s, shl_s, shr_s;
  logic [SHW-1:0]     shamt_s;
  logic [WIDTH-1:0]   res_s, fin_res_s;
  logic               c_s, v_s, fin_c_s, fin_v_s;
  logic               load_s, capture_s, sel_mul_s;
  logic [2*WIDTH-1:0] product_s;
  logic               mul_last_s;

  seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clock   (clock),
    .reset   (reset),
    .load    (load_s),
    .a       (bus.in1),
    .b       (bus.in2),
    .product (product_s),
    .last    (mul_last_s)
  );

  // Single-cycle operations; the extra top bit of each wide result is the carry/shift-out.
  always_comb begin
    shamt_s = bus.in2[SHW-1:0];
    add_s   = {1'b0, bus.in1} + {1'b0, bus.in2};
    sub_s   = {1'b0, bus.in1} - {1'b0, bus.in2};
    shl_s   = {1'b0, bus.in1} << shamt_s;
    shr_s   = {bus.in1, 1'b0} >> shamt_s;
    res_s   = {WIDTH{1'b0}};
    c_s     = 1'b0;
    v_s     = 1'b0;
    case (bus.ALUOp)
      OP_ADD: begin
        res_s = add_s[WIDTH-1:0];
        c_s   = add_s[WIDTH];
        v_s   = add_ovf(bus.in1[WIDTH-1], bus.in2[WIDTH-1], add_s[WIDTH-1]);
      end
      OP_SUB: begin
        res_s = sub_s[WIDTH-1:0];
        c_s   = ~sub_s[WIDTH];
        v_s   = sub_ovf(bus.in1[WIDTH-1], bus.in2[WIDTH-1], sub_s[WIDTH-1]);
      end
      OP_OR:   res_s = bus.in1 | bus.in2;
      OP_NAND: res_s = ~(bus.in1 & bus.in2);
      OP_SHIFT: begin
        if (bus.in2[SHW]) begin
          res_s = shl_s[WIDTH-1:0];
          c_s   = shl_s[WIDTH];
        end else begin
          res_s = shr_s[WIDTH:1];
          c_s   = shr_s[0];
        end
      end
      default: res_s = {WIDTH{1'b0}};
    endcase
  end

  // FSM next state and capture controls.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    capture_s    = 1'b0;
    sel_mul_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.ALUOp == OP_MUL) begin
            load_s       = 1'b1;
            state_next_s = S_MUL;
          end else begin
            capture_s    = 1'b1;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_last_s) begin
          capture_s    = 1'b1;
          sel_mul_s    = 1'b1;
          state_next_s = S_IDLE;
        end else begin
          state_next_s = S_MUL;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // Result source: multiplier on completion, otherwise the single-cycle path.
  always_comb begin
    fin_res_s = sel_mul_s ? product_s[WIDTH-1:0] : res_s;
    fin_c_s   = sel_mul_s ? (|product_s[2*WIDTH-1:WIDTH]) : c_s;
    fin_v_s   = sel_mul_s ? 1'b0 : v_s;
  end

  // State, result and flag registers; results hold until the next capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= S_IDLE;
      out_r   <= {WIDTH{1'b0}};
      n_r     <= 1'b0;
      z_r     <= 1'b1;
      c_r     <= 1'b0;
      v_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == S_MUL);
      done_r  <= capture_s;
      if (capture_s) begin
        out_r <= fin_res_s;
        n_r   <= fin_res_s[WIDTH-1];
        z_r   <= (fin_res_s == {WIDTH{1'b0}});
        c_r   <= fin_c_s;
        v_r   <= fin_v_s;
      end
    end
  end

  assign bus.out  = out_r;
  assign bus.N    = n_r;
  assign bus.Z    = z_r;
  assign bus.C    = c_r;
  assign bus.V    = v_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU for the processor datapath. It replaces the 8-bit combinational ALU. It keeps opcodes 0–4 bit-compatible and adds a sequential shift-add multiply. It also adds carry and overflow flags and a start/busy/done handshake, so the controller can stall on multi-cycle operations. Operands and the opcode are captured on `start`; the result and flags are registered and held until the next completion.

## Interface
- `WIDTH`, default 8: operand and result width. Must be ≥ 4 and a power of 2.
- `SHW`, default `$clog2(WIDTH)`: width of the shift-amount field. Derived; do not override.
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `reset`  in  1  — reset is synchronous and active-high.
- `start`  in  1  — request an operation. Sampled only when `busy`=0.
- `ALUOp`  in  3  — operation select, captured with `start`.
- `in1`  in  WIDTH  — operand A, captured with `start`.
- `in2`  in  WIDTH  — operand B, captured with `start`.
- `out`  out  WIDTH  — registered result.
- `N`, `Z`, `C`, `V`  out  1 each  — registered flags.
- `busy`  out  1  — a multi-cycle operation is in progress.
- `done`  out  1  — one-cycle pulse: `out` and the flags were just updated.

## Operation
- Opcodes:
  - 000 add: `in1+in2`.
  - 001 sub: `in1−in2`.
  - 010 or.
  - 011 nand.
  - 100 shift.
  - 101 mul: low WIDTH bits of the unsigned product.
  - 110, 111 reserved: `out`=0.
- Shift (100):
  - Amount is `in2[SHW-1:0]`; direction is `in2[SHW]` (1 = left logical, 0 = right logical).
  - Upper bits of `in2` are ignored.
  - Amount 0 gives `out`=`in1`.
- Flags, all registered together with `out`:
  - N = `out[WIDTH-1]`.
  - Z = (`out`==0).
  - C:
    - add: carry-out.
    - sub: not-borrow, i.e. 1 iff `in1`≥`in2` unsigned.
    - shift: last bit shifted out, 0 if amount 0.
    - mul: 1 iff the high half of the product ≠ 0.
    - otherwise 0.
  - V: two's-complement overflow for add/sub; 0 otherwise.
- State machine:
  - IDLE:
    - `start`=1 with a non-mul op: compute, register result and flags, pulse `done`; stay in IDLE.
    - `start`=1 with mul: load the multiplicand, multiplier and a zeroed 2·WIDTH accumulator, clear the counter, go to MUL.
  - MUL:
    - Each cycle: if multiplier LSB=1, add the multiplicand into the accumulator high half; shift the accumulator right 1 (carry kept); shift the multiplier right 1; increment the counter.
    - After WIDTH iterations: register result and flags, pulse `done`, return to IDLE.
- `start` while `busy`=1 is ignored and not queued. Input changes during MUL have no effect.
- `out` and the flags hold their values between `done` pulses.
- Reset, including mid-MUL: state IDLE, counter 0, `out`=0, N=0, Z=1, C=0, V=0, `busy`=0, `done`=0. Any in-flight mul is discarded and `done` does not fire for it.
- `start` coincident with `reset`: reset wins; the request is dropped.

## Timing
- Let E0 be the rising edge at which `start`=1 is accepted.
- Non-mul ops:
  - `out`, flags and `done`=1 are valid in the cycle after E0 (latency 1).
  - `busy` stays 0.
  - A new `start` in that same cycle is accepted; back-to-back throughput is 1 op/cycle.
- Mul:
  - `busy`=1 from after E0 through after edge E0+WIDTH−1.
  - At edge E0+WIDTH: result registered, `busy`=0, `done`=1. Latency is WIDTH cycles.
  - `start` is accepted again starting at edge E0+WIDTH+1, i.e. in the cycle where `done`=1.
- `done` is never high for two consecutive cycles unless two ops complete back to back.

## Structure
- Package `alu_pkg` holds:
  - ALUOp constants `OP_ADD`, `OP_SUB`, `OP_OR`, `OP_NAND`, `OP_SHIFT`, `OP_MUL`.
  - The state enum `{S_IDLE, S_MUL}`.
- Sub-module `seq_mul` (parameter `WIDTH`; ports `clock`, `reset`, `load`, `a`, `b`, `product[2*WIDTH-1:0]`, `last`) holds the shift-add datapath and iteration counter.
- The top level holds the combinational single-cycle ops, flag logic, FSM and output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: assert `reset` for 2 cycles → `out`=0, N=0, Z=1, C=0, V=0, `busy`=0, `done`=0.
- add 0x7F+0x01 → `out`=0x80, N=1, Z=0, C=0, V=1, `done` one cycle after `start`.
- add 0xFF+0x01 → `out`=0x00, Z=1, C=1, V=0.
- sub 0x03−0x05 → `out`=0xFE, N=1, C=0.
- Shift:
  - `in1`=0x81, `in2`=0x09 (left by 1) → `out`=0x02, C=1.
  - `in2`=0x03 (right by 3) → `out`=0x10, C=0.
- Mul 0x0F×0x11 → `out`=0xFF, C=0, `done` exactly 8 cycles after `start`.
  - 0x10×0x10 → `out`=0x00, Z=1, C=1.
  - A `start` (add) issued while `busy` is ignored.
  - `reset` asserted at iteration 4 → no `done`, outputs at reset values.
- Back-to-back: or 0xF0|0x0F then nand 0xFF,0xFF on consecutive cycles → `done` 2 cycles in a row; `out`=0xFF, then 0x00 with Z=1.
